laser_host: RTL and testbench

Host-side driver and checker for the LASER two-circle cover engine. Holds a 40-point set written by a controller and streams it onto the engine's X/Y input, one point per cycle, immediately after releasing the engine's reset. It then waits for DONE, captures the two circle centres, scores how many points the two circles cover, and reports the result. It sits between the system/test controller and a LASER instance: it drives the engine's X/Y/reset and samples its C1X/C1Y/C2X/C2Y/DONE.

---
 rtl/laser_host.sv | 240 ++++++++++++++++++++++++
 tb/tb_laser_host.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/laser_host.sv
// laser_host -- host-side driver and checker for the LASER two-circle cover engine.
//
// Holds a NPTS-entry point set written by a controller. On START it releases
// the engine reset and streams the points onto X/Y, one per cycle. It then
// waits for the engine DONE, captures both circle centres and (optionally)
// scores how many stored points the two circles cover, then pulses RES_VALID.
//
// Build option: define LASER_HOST_SCORE_EN to include the SCORE state. When it
// is not defined, WAIT goes straight to REPORT and COVER stays 0.
//
// Ports:
//   CLK, RST                    clock, synchronous active-high reset
//   WR_EN/WR_ADDR/WR_X/WR_Y     point-memory write port (ignored while BUSY)
//   START                       begin a run (sampled only while idle)
//   BUSY                        run in progress
//   LRST                        engine reset (1 while idle)
//   X, Y                        point stream to the engine (0 outside FEED)
//   DONE_I, C1X_I..C2Y_I        engine done flag and circle centres
//   RES_VALID                   one-cycle result strobe
//   RES_C1X..RES_C2Y, COVER     captured centres and covered-point count
//   TIMEOUT                     sticky: engine never raised DONE

module laser_host #(
   parameter int NPTS   = 40,
   parameter int TO_CYC = 4095
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       WR_EN,
   input  logic [5:0] WR_ADDR,
   input  logic [3:0] WR_X,
   input  logic [3:0] WR_Y,
   input  logic       START,
   output logic       BUSY,
   output logic       LRST,
   output logic [3:0] X,
   output logic [3:0] Y,
   input  logic       DONE_I,
   input  logic [3:0] C1X_I,
   input  logic [3:0] C1Y_I,
   input  logic [3:0] C2X_I,
   input  logic [3:0] C2Y_I,
   output logic       RES_VALID,
   output logic [3:0] RES_C1X,
   output logic [3:0] RES_C1Y,
   output logic [3:0] RES_C2X,
   output logic [3:0] RES_C2Y,
   output logic [5:0] COVER,
   output logic       TIMEOUT
);

   localparam logic [5:0]  CNT_LAST = 6'(NPTS - 1);
   localparam logic [5:0]  ADDR_LIM = 6'(NPTS);
   localparam logic [11:0] TO_LAST  = 12'(TO_CYC - 1);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FEED   = 3'd1,
      ST_WAIT   = 3'd2,
`ifdef LASER_HOST_SCORE_EN
      ST_SCORE  = 3'd3,
`endif
      ST_REPORT = 3'd4
   } state_t;

   state_t      state_r;
   logic [5:0]  cnt_r;
   logic [11:0] wcnt_r;
   logic        busy_r;
   logic        lrst_r;
   logic [3:0]  x_r;
   logic [3:0]  y_r;
   logic [3:0]  res_c1x_r;
   logic [3:0]  res_c1y_r;
   logic [3:0]  res_c2x_r;
   logic [3:0]  res_c2y_r;
   logic [5:0]  cover_r;
   logic        res_valid_r;
   logic        timeout_r;

   logic [7:0]  mem_r [NPTS];
   logic [5:0]  nxt_cnt_s;
   logic        wr_ok_s;

   assign nxt_cnt_s = cnt_r + 6'd1;
   assign wr_ok_s   = WR_EN & ~busy_r & (WR_ADDR < ADDR_LIM);

`ifdef LASER_HOST_SCORE_EN
   logic [5:0] acc_r;
   logic [7:0] pt_s;
   logic       hit_s;

   function automatic logic [3:0] abs_diff(input logic [3:0] a, input logic [3:0] b);
      return (a >= b) ? (a - b) : (b - a);
   endfunction

   // Square of a 4-bit distance in 5 bits; any distance above 5 is already
   // far outside the radius, so it saturates instead of wrapping.
   function automatic logic [4:0] sq5(input logic [3:0] d);
      logic [4:0] dd;
      dd = {1'b0, d};
      return (d > 4'd5) ? 5'd31 : (dd * dd);
   endfunction

   function automatic logic in_circle(input logic [3:0] cx, input logic [3:0] cy,
                                      input logic [3:0] px, input logic [3:0] py);
      logic [5:0] sum;
      sum = {1'b0, sq5(abs_diff(cx, px))} + {1'b0, sq5(abs_diff(cy, py))};
      return (sum <= 6'd16);
   endfunction

   assign pt_s  = mem_r[cnt_r];
   // A point inside both circles still counts only once.
   assign hit_s = in_circle(res_c1x_r, res_c1y_r, pt_s[7:4], pt_s[3:0]) |
                  in_circle(res_c2x_r, res_c2y_r, pt_s[7:4], pt_s[3:0]);
`endif

   // Point memory write port; deliberately not reset so the set survives RST and runs
   always_ff @(posedge CLK) begin
      if (wr_ok_s) begin
         mem_r[WR_ADDR] <= {WR_X, WR_Y};
      end
   end

   // Run sequencer: feed, wait for DONE, optional scoring, result report
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_r     <= ST_IDLE;
         cnt_r       <= 6'd0;
         wcnt_r      <= 12'd0;
         busy_r      <= 1'b0;
         lrst_r      <= 1'b1;
         x_r         <= 4'd0;
         y_r         <= 4'd0;
         res_c1x_r   <= 4'd0;
         res_c1y_r   <= 4'd0;
         res_c2x_r   <= 4'd0;
         res_c2y_r   <= 4'd0;
         cover_r     <= 6'd0;
         res_valid_r <= 1'b0;
         timeout_r   <= 1'b0;
`ifdef LASER_HOST_SCORE_EN
         acc_r       <= 6'd0;
`endif
      end else begin
         res_valid_r <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (START) begin
                  state_r    <= ST_FEED;
                  cnt_r      <= 6'd0;
                  busy_r     <= 1'b1;
                  lrst_r     <= 1'b0;
                  timeout_r  <= 1'b0;
                  {x_r, y_r} <= mem_r[6'd0];
               end
            end
            ST_FEED: begin
               // X/Y always shows point[cnt_r]; the engine samples it one edge later.
               if (cnt_r == CNT_LAST) begin
                  state_r <= ST_WAIT;
                  wcnt_r  <= 12'd0;
                  x_r     <= 4'd0;
                  y_r     <= 4'd0;
               end else begin
                  cnt_r      <= nxt_cnt_s;
                  {x_r, y_r} <= mem_r[nxt_cnt_s];
               end
            end
            ST_WAIT: begin
               if (DONE_I) begin
                  res_c1x_r <= C1X_I;
                  res_c1y_r <= C1Y_I;
                  res_c2x_r <= C2X_I;
                  res_c2y_r <= C2Y_I;
                  cnt_r     <= 6'd0;
`ifdef LASER_HOST_SCORE_EN
                  acc_r     <= 6'd0;
                  state_r   <= ST_SCORE;
`else
                  state_r   <= ST_REPORT;
`endif
               end else if (wcnt_r == TO_LAST) begin
                  timeout_r <= 1'b1;
                  state_r   <= ST_IDLE;
                  busy_r    <= 1'b0;
                  lrst_r    <= 1'b1;
               end else begin
                  wcnt_r <= wcnt_r + 12'd1;
               end
            end
`ifdef LASER_HOST_SCORE_EN
            ST_SCORE: begin
               acc_r <= acc_r + {5'd0, hit_s};
               if (cnt_r == CNT_LAST) begin
                  state_r <= ST_REPORT;
               end else begin
                  cnt_r <= nxt_cnt_s;
               end
            end
`endif
            ST_REPORT: begin
               // First cycle raises the strobe, second cycle returns to idle.
               if (!res_valid_r) begin
                  res_valid_r <= 1'b1;
`ifdef LASER_HOST_SCORE_EN
                  cover_r     <= acc_r;
`else
                  cover_r     <= 6'd0;
`endif
               end else begin
                  state_r <= ST_IDLE;
                  busy_r  <= 1'b0;
                  lrst_r  <= 1'b1;
               end
            end
            default: begin
               state_r <= ST_IDLE;
               busy_r  <= 1'b0;
               lrst_r  <= 1'b1;
               x_r     <= 4'd0;
               y_r     <= 4'd0;
            end
         endcase
      end
   end

   assign BUSY      = busy_r;
   assign LRST      = lrst_r;
   assign X         = x_r;
   assign Y         = y_r;
   assign RES_VALID = res_valid_r;
   assign RES_C1X   = res_c1x_r;
   assign RES_C1Y   = res_c1y_r;
   assign RES_C2X   = res_c2x_r;
   assign RES_C2Y   = res_c2y_r;
   assign COVER     = cover_r;
   assign TIMEOUT   = timeout_r;

endmodule

// File: tb/tb_laser_host.sv
// Directed self-checking bench for laser_host; the bench plays the engine.
module tb_laser_host;
   localparam int NPTS   = 40;
   localparam int TO_CYC = 4095;
`ifdef LASER_HOST_SCORE_EN
   localparam bit SCORE_ON = 1'b1;
`else
   localparam bit SCORE_ON = 1'b0;
`endif

   logic       CLK = 1'b0;
   logic       RST, WR_EN, START, DONE_I;
   logic [5:0] WR_ADDR;
   logic [3:0] WR_X, WR_Y, C1X_I, C1Y_I, C2X_I, C2Y_I;
   logic       BUSY, LRST, RES_VALID, TIMEOUT;
   logic [3:0] X, Y, RES_C1X, RES_C1Y, RES_C2X, RES_C2Y;
   logic [5:0] COVER;

   int total = 0;
   int bad   = 0;
   logic [3:0] px [NPTS];
   logic [3:0] py [NPTS];

   always #5 CLK = ~CLK;

   laser_host #(.NPTS(NPTS), .TO_CYC(TO_CYC)) dut (
      .CLK(CLK), .RST(RST), .WR_EN(WR_EN), .WR_ADDR(WR_ADDR), .WR_X(WR_X), .WR_Y(WR_Y),
      .START(START), .BUSY(BUSY), .LRST(LRST), .X(X), .Y(Y), .DONE_I(DONE_I),
      .C1X_I(C1X_I), .C1Y_I(C1Y_I), .C2X_I(C2X_I), .C2Y_I(C2Y_I),
      .RES_VALID(RES_VALID), .RES_C1X(RES_C1X), .RES_C1Y(RES_C1Y),
      .RES_C2X(RES_C2X), .RES_C2Y(RES_C2Y), .COVER(COVER), .TIMEOUT(TIMEOUT)
   );

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic wr_pt(input int a, input logic [3:0] x, input logic [3:0] y);
      WR_EN = 1'b1; WR_ADDR = 6'(a); WR_X = x; WR_Y = y;
      tick();
      WR_EN = 1'b0;
      px[a] = x; py[a] = y;
   endtask

   // One full run: START, stream check, engine DONE after dly WAIT cycles, result check.
   task automatic do_run(input string tag, input logic [3:0] c1x, input logic [3:0] c1y,
                         input logic [3:0] c2x, input logic [3:0] c2y, input int dly,
                         input bit pulse, input bit feed_done, input int exp_cover);
      int cyc;
      int exp_lat;
      logic [5:0] exp_cv;
      exp_cv  = SCORE_ON ? 6'(exp_cover) : 6'd0;
      exp_lat = SCORE_ON ? NPTS + 1 : 1;
      START = 1'b1;
      tick();
      START = 1'b0;
      total++;
      if (LRST !== 1'b0 || BUSY !== 1'b1 || TIMEOUT !== 1'b0) begin
         bad++;
         $display("FAIL %s start: LRST=%b BUSY=%b TIMEOUT=%b, want 0 1 0", tag, LRST, BUSY, TIMEOUT);
      end
      for (int i = 0; i < NPTS; i++) begin
         if (i > 0) tick();
         DONE_I = feed_done && (i == 20);
         total++;
         if (X !== px[i] || Y !== py[i]) begin
            bad++;
            $display("FAIL %s stream[%0d]: got (%0d,%0d), want (%0d,%0d)", tag, i, X, Y, px[i], py[i]);
         end
      end
      DONE_I = 1'b0;
      tick();
      total++;
      if (X !== 4'd0 || Y !== 4'd0 || BUSY !== 1'b1 || LRST !== 1'b0) begin
         bad++;
         $display("FAIL %s wait_entry: X=%0d Y=%0d BUSY=%b LRST=%b, want 0 0 1 0", tag, X, Y, BUSY, LRST);
      end
      for (int j = 0; j < dly; j++) begin
         if (pulse && j == 1) begin
            WR_EN = 1'b1; WR_ADDR = 6'd0; WR_X = ~px[0]; WR_Y = ~py[0]; START = 1'b1;
         end else begin
            WR_EN = 1'b0; START = 1'b0;
         end
         tick();
      end
      WR_EN = 1'b0; START = 1'b0;
      C1X_I = c1x; C1Y_I = c1y; C2X_I = c2x; C2Y_I = c2y; DONE_I = 1'b1;
      tick();
      DONE_I = 1'b0;
      C1X_I = ~c1x; C1Y_I = ~c1y; C2X_I = ~c2x; C2Y_I = ~c2y;
      total++;
      if ({RES_C1X, RES_C1Y, RES_C2X, RES_C2Y} !== {c1x, c1y, c2x, c2y}) begin
         bad++;
         $display("FAIL %s capture: got %h, want %h", tag,
                  {RES_C1X, RES_C1Y, RES_C2X, RES_C2Y}, {c1x, c1y, c2x, c2y});
      end
      cyc = 0;
      while (RES_VALID !== 1'b1 && cyc < 200) begin
         DONE_I = (cyc == 3);
         tick();
         cyc++;
      end
      DONE_I = 1'b0;
      total++;
      if (cyc != exp_lat) begin
         bad++;
         $display("FAIL %s latency: RES_VALID after %0d cycles, want %0d", tag, cyc, exp_lat);
      end
      total++;
      if (COVER !== exp_cv) begin
         bad++;
         $display("FAIL %s cover: got %0d, want %0d", tag, COVER, exp_cv);
      end
      total++;
      if ({RES_C1X, RES_C1Y, RES_C2X, RES_C2Y} !== {c1x, c1y, c2x, c2y} || BUSY !== 1'b1) begin
         bad++;
         $display("FAIL %s hold: centres %h BUSY=%b, want %h 1", tag,
                  {RES_C1X, RES_C1Y, RES_C2X, RES_C2Y}, BUSY, {c1x, c1y, c2x, c2y});
      end
      tick();
      total++;
      if (RES_VALID !== 1'b0 || BUSY !== 1'b0 || LRST !== 1'b1 || COVER !== exp_cv) begin
         bad++;
         $display("FAIL %s end: RES_VALID=%b BUSY=%b LRST=%b COVER=%0d, want 0 0 1 %0d",
                  tag, RES_VALID, BUSY, LRST, COVER, exp_cv);
      end
   endtask

   task automatic test_reset();
      RST = 1'b1;
      tick();
      tick();
      total++;
      if (LRST !== 1'b1 || BUSY !== 1'b0 || RES_VALID !== 1'b0 || TIMEOUT !== 1'b0) begin
         bad++;
         $display("FAIL reset_ctrl: LRST=%b BUSY=%b RES_VALID=%b TIMEOUT=%b, want 1 0 0 0",
                  LRST, BUSY, RES_VALID, TIMEOUT);
      end
      total++;
      if ({X, Y} !== 8'h00 || {RES_C1X, RES_C1Y, RES_C2X, RES_C2Y} !== 16'h0000 || COVER !== 6'd0) begin
         bad++;
         $display("FAIL reset_data: XY=%h RES=%h COVER=%0d, want 00 0000 0",
                  {X, Y}, {RES_C1X, RES_C1Y, RES_C2X, RES_C2Y}, COVER);
      end
      RST = 1'b0;
   endtask

   task automatic test_all_same();
      for (int i = 0; i < NPTS; i++) wr_pt(i, 4'd8, 4'd8);
      do_run("all_same", 4'd8, 4'd8, 4'd0, 4'd0, 3, 1'b0, 1'b0, 40);
   endtask

   task automatic test_cover_edge();
      for (int i = 0; i < 5; i++) wr_pt(i, 4'(i), 4'd0);
      for (int i = 5; i < NPTS; i++) wr_pt(i, 4'd15, 4'd15);
      do_run("edge_r4", 4'd0, 4'd0, 4'd15, 4'd15, 0, 1'b0, 1'b0, 40);
      wr_pt(4, 4'd5, 4'd0);
      do_run("edge_r5", 4'd0, 4'd0, 4'd15, 4'd15, 1, 1'b0, 1'b0, 39);
   endtask

   task automatic test_diag();
      wr_pt(4, 4'd4, 4'd0);
      wr_pt(0, 4'd3, 4'd3);
      do_run("diag_33", 4'd0, 4'd0, 4'd15, 4'd15, 2, 1'b0, 1'b1, 39);
      wr_pt(0, 4'd2, 4'd3);
      do_run("diag_23", 4'd0, 4'd0, 4'd15, 4'd15, 4, 1'b0, 1'b0, 40);
   endtask

   task automatic test_timeout();
      int cyc;
      bit seen_valid;
      START = 1'b1;
      tick();
      START = 1'b0;
      for (int i = 1; i <= NPTS; i++) tick();
      cyc = 0;
      seen_valid = 1'b0;
      while (TIMEOUT !== 1'b1 && cyc < TO_CYC + 100) begin
         tick();
         cyc++;
         if (RES_VALID === 1'b1) seen_valid = 1'b1;
      end
      total++;
      if (cyc != TO_CYC) begin
         bad++;
         $display("FAIL timeout_delay: TIMEOUT after %0d cycles, want %0d", cyc, TO_CYC);
      end
      total++;
      if (LRST !== 1'b1 || BUSY !== 1'b0 || seen_valid) begin
         bad++;
         $display("FAIL timeout_state: LRST=%b BUSY=%b valid_seen=%b, want 1 0 0", LRST, BUSY, seen_valid);
      end
      tick();
      tick();
      total++;
      if (TIMEOUT !== 1'b1) begin
         bad++;
         $display("FAIL timeout_sticky: TIMEOUT=%b, want 1", TIMEOUT);
      end
      do_run("after_to", 4'd0, 4'd0, 4'd15, 4'd15, 3, 1'b0, 1'b0, 40);
   endtask

   task automatic test_reset_mid_feed();
      START = 1'b1;
      tick();
      START = 1'b0;
      for (int i = 1; i <= 20; i++) tick();
      total++;
      if (X !== px[20] || Y !== py[20]) begin
         bad++;
         $display("FAIL mid_feed_pt20: got (%0d,%0d), want (%0d,%0d)", X, Y, px[20], py[20]);
      end
      RST = 1'b1;
      tick();
      RST = 1'b0;
      total++;
      if (LRST !== 1'b1 || BUSY !== 1'b0 || X !== 4'd0 || Y !== 4'd0) begin
         bad++;
         $display("FAIL mid_reset_ctrl: LRST=%b BUSY=%b X=%0d Y=%0d, want 1 0 0 0", LRST, BUSY, X, Y);
      end
      total++;
      if ({RES_C1X, RES_C1Y, RES_C2X, RES_C2Y} !== 16'h0000 || COVER !== 6'd0 || RES_VALID !== 1'b0) begin
         bad++;
         $display("FAIL mid_reset_res: RES=%h COVER=%0d RES_VALID=%b, want 0000 0 0",
                  {RES_C1X, RES_C1Y, RES_C2X, RES_C2Y}, COVER, RES_VALID);
      end
      tick();
      tick();
      total++;
      if (BUSY !== 1'b0 || LRST !== 1'b1) begin
         bad++;
         $display("FAIL mid_reset_idle: BUSY=%b LRST=%b, want 0 1", BUSY, LRST);
      end
      do_run("replay", 4'd0, 4'd0, 4'd15, 4'd15, 2, 1'b0, 1'b0, 40);
   endtask

   task automatic test_busy_pulses();
      do_run("wait_pulse", 4'd0, 4'd0, 4'd15, 4'd15, 4, 1'b1, 1'b0, 40);
      do_run("post_pulse", 4'd0, 4'd3, 4'd15, 4'd15, 2, 1'b0, 1'b0, 38);
   endtask

   initial begin
      RST = 1'b1; WR_EN = 1'b0; WR_ADDR = 6'd0; WR_X = 4'd0; WR_Y = 4'd0;
      START = 1'b0; DONE_I = 1'b0;
      C1X_I = 4'd0; C1Y_I = 4'd0; C2X_I = 4'd0; C2Y_I = 4'd0;
      test_reset();
      test_all_same();
      test_cover_edge();
      test_diag();
      test_timeout();
      test_reset_mid_feed();
      test_busy_pulses();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
